// File: rtl/protobuf_pkg.sv
// Shared types and constants for the protobuf serializer front end.
// TABLE_ENTRY is the decoded form of one 16-byte type-table record.
package protobuf_pkg;

  localparam int ENTRY_BYTES     = 16;
  localparam int LANES           = 8;
  localparam int FLAG_NESTED_BIT = 0;
  localparam int FLAG_LAST_BIT   = 1;

  localparam logic DRAM_RD = 1'b0;
  localparam logic DRAM_WR = 1'b1;

  typedef struct packed {
    logic [15:0] field_id;
    logic [7:0]  field_type;
    logic [15:0] offset;
    logic [15:0] size;
    logic        nested;
    logic [63:0] nested_type_table;
  } TABLE_ENTRY;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_REQ_HI,
    ST_EMIT,
    ST_DONE
  } fetch_state_e;

  // lo = record bytes 0-7, hi = bytes 8-15, both little-endian.
  function automatic TABLE_ENTRY decode_entry(input logic [63:0] lo, input logic [63:0] hi);
    TABLE_ENTRY e;
    e.field_id          = lo[15:0];
    e.field_type        = lo[23:16];
    e.nested            = lo[24 + FLAG_NESTED_BIT];
    e.offset            = lo[47:32];
    e.size              = lo[63:48];
    e.nested_type_table = hi;
    return e;
  endfunction

endpackage

// File: rtl/dram_word_reader.sv
// Issues one 8-lane DRAM read at base..base+7 and returns the assembled 64-bit word.
// done is combinational on the cycle all lanes are valid together; abort wins over done.
module dram_word_reader
  import protobuf_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [63:0]            base,
  input  logic [LANES-1:0]       dram_valid,
  input  logic [LANES-1:0][7:0]  dram_data,
  output logic [LANES-1:0]       dram_en,
  output logic [LANES-1:0][63:0] dram_addr,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            word
);

  logic        busy_q, busy_d;
  logic [63:0] base_q, base_d;

  always_comb begin
    busy_d = busy_q;
    base_d = base_q;
    done   = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (&dram_valid) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      base_d = base;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      base_q <= '0;
    end else begin
      busy_q <= busy_d;
      base_q <= base_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dram_addr[i] = busy_q ? (base_q + 64'(i)) : 64'h0;
    end
  end

  assign dram_en = busy_q ? '1 : '0;
  assign busy    = busy_q;
  assign word    = dram_data;

endmodule

// File: rtl/fetch.sv
// Type-table fetch unit: walks 16-byte records from a base address, decodes each
// into a TABLE_ENTRY and hands it to the object buffer over a valid/full handshake.
module fetch
  import protobuf_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [63:0]            new_addr,
  input  logic                   new_addr_valid,
  input  logic [LANES-1:0]       dram_valid,
  input  logic [LANES-1:0][7:0]  dram_data,
  output logic [LANES-1:0]       dram_en,
  output logic                   dram_rdwr,
  output logic [LANES-1:0][63:0] dram_addr,
  output TABLE_ENTRY             entry,
  input  logic                   ob_full,
  output logic                   ob_valid
);

  fetch_state_e state_q, state_d;
  logic [63:0]  addr_q, addr_d;
  logic [63:0]  lo_q, lo_d;
  logic         loaded_q, loaded_d;
  logic         last_q, last_d;
  logic         ob_valid_q, ob_valid_d;
  TABLE_ENTRY   entry_q, entry_d;

  logic         rd_start;
  logic [63:0]  rd_base;
  logic         rd_busy;
  logic         rd_done;
  logic [63:0]  rd_word;

  dram_word_reader u_reader (
    .clk        (clk),
    .reset      (reset),
    .start      (rd_start),
    .abort      (new_addr_valid),
    .base       (rd_base),
    .dram_valid (dram_valid),
    .dram_data  (dram_data),
    .dram_en    (dram_en),
    .dram_addr  (dram_addr),
    .busy       (rd_busy),
    .done       (rd_done),
    .word       (rd_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    loaded_d   = loaded_q;
    last_d     = last_q;
    ob_valid_d = ob_valid_q;
    entry_d    = entry_q;
    rd_start   = 1'b0;
    rd_base    = addr_q;

    if (new_addr_valid) begin
      addr_d     = new_addr;
      loaded_d   = 1'b1;
      ob_valid_d = 1'b0;
      state_d    = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && loaded_q) state_d = ST_REQ_LO;
        end
        ST_REQ_LO: begin
          if (rd_done) begin
            lo_d    = rd_word;
            state_d = ST_REQ_HI;
          end else if (!rd_busy && en) begin
            rd_start = 1'b1;
          end
        end
        ST_REQ_HI: begin
          rd_base = addr_q + 64'(LANES);
          if (rd_done) begin
            entry_d    = decode_entry(lo_q, rd_word);
            last_d     = lo_q[24 + FLAG_LAST_BIT];
            ob_valid_d = 1'b1;
            state_d    = ST_EMIT;
          end else if (!rd_busy && en) begin
            rd_start = 1'b1;
          end
        end
        ST_EMIT: begin
          if (!ob_full) begin
            ob_valid_d = 1'b0;
            if (last_q) begin
              state_d = ST_DONE;
            end else begin
              addr_d  = addr_q + 64'(ENTRY_BYTES);
              state_d = en ? ST_REQ_LO : ST_IDLE;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      lo_q       <= '0;
      loaded_q   <= 1'b0;
      last_q     <= 1'b0;
      ob_valid_q <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      loaded_q   <= loaded_d;
      last_q     <= last_d;
      ob_valid_q <= ob_valid_d;
      entry_q    <= entry_d;
    end
  end

  assign entry     = entry_q;
  assign ob_valid  = ob_valid_q;
  assign dram_rdwr = DRAM_RD;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a small byte-array DRAM model answers lane requests
// in one of three modes (immediate, staggered lanes, hold the upper half).
module tb_fetch;
  import protobuf_pkg::*;

  logic                   clk;
  logic                   reset;
  logic                   en;
  logic [63:0]            new_addr;
  logic                   new_addr_valid;
  logic [LANES-1:0]       dram_valid;
  logic [LANES-1:0][7:0]  dram_data;
  logic [LANES-1:0]       dram_en;
  logic                   dram_rdwr;
  logic [LANES-1:0][63:0] dram_addr;
  TABLE_ENTRY             entry;
  logic                   ob_full;
  logic                   ob_valid;

  int n_checks;
  int n_errors;

  logic [7:0]  mem [0:1023];
  int          resp_mode;
  int          resp_cnt;
  logic [63:0] lo_log [$];
  logic [63:0] hi_log [$];

  fetch dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .new_addr       (new_addr),
    .new_addr_valid (new_addr_valid),
    .dram_valid     (dram_valid),
    .dram_data      (dram_data),
    .dram_en        (dram_en),
    .dram_rdwr      (dram_rdwr),
    .dram_addr      (dram_addr),
    .entry          (entry),
    .ob_full        (ob_full),
    .ob_valid       (ob_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: mode 0 answers on the first cycle, mode 1 pulses single lanes with
  // junk data for 8 cycles then answers all lanes on cycle 11, mode 2 never answers
  // requests whose base has bit 3 set (the upper half of a record).
  always @(negedge clk) begin
    if (dram_en == 8'hFF) begin
      resp_cnt = resp_cnt + 1;
      if (resp_cnt == 1) begin
        lo_log.push_back(dram_addr[0]);
        hi_log.push_back(dram_addr[7]);
      end
    end else begin
      resp_cnt = 0;
    end
    dram_valid = '0;
    for (int i = 0; i < LANES; i++) dram_data[i] = 8'hEE;
    if (dram_en == 8'hFF) begin
      if (resp_mode == 1 && resp_cnt >= 1 && resp_cnt <= 8) begin
        dram_valid = 8'(1) << (resp_cnt - 1);
      end else if ((resp_mode == 0 && resp_cnt >= 1) ||
                   (resp_mode == 1 && resp_cnt >= 11) ||
                   (resp_mode == 2 && resp_cnt >= 1 && !dram_addr[0][3])) begin
        dram_valid = '1;
        for (int i = 0; i < LANES; i++) dram_data[i] = mem[dram_addr[i][9:0]];
      end
    end
  end

  task automatic put_rec(input int base, input logic [15:0] id, input logic [7:0] ftype,
                         input logic [7:0] flags, input logic [15:0] off,
                         input logic [15:0] sz, input logic [63:0] ntt);
    mem[base + 0] = id[7:0];
    mem[base + 1] = id[15:8];
    mem[base + 2] = ftype;
    mem[base + 3] = flags;
    mem[base + 4] = off[7:0];
    mem[base + 5] = off[15:8];
    mem[base + 6] = sz[7:0];
    mem[base + 7] = sz[15:8];
    for (int i = 0; i < 8; i++) mem[base + 8 + i] = ntt[8*i +: 8];
  endtask

  // Called at posedge+1 phase; leaves the bench at posedge+1 phase.
  task automatic load(input logic [63:0] a);
    new_addr       = a;
    new_addr_valid = 1'b1;
    @(posedge clk); #1;
    new_addr_valid = 1'b0;
  endtask

  task automatic wait_ob(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (ob_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dram_en !== 8'h00) begin n_errors++; $display("FAIL reset_dram_en: got %h want 00", dram_en); end
    n_checks++;
    if (ob_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ob_valid: got %b want 0", ob_valid); end
    n_checks++;
    if (entry !== '0) begin n_errors++; $display("FAIL reset_entry: got %h want 0", entry); end
    n_checks++;
    if (dram_rdwr !== 1'b0) begin n_errors++; $display("FAIL reset_dram_rdwr: got %b want 0", dram_rdwr); end
    n_checks++;
    if (dram_addr !== '0) begin n_errors++; $display("FAIL reset_dram_addr: got %h want 0", dram_addr); end
    reset = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  task automatic test_single();
    TABLE_ENTRY exp;
    bit ok;
    exp = '{field_id:16'h1234, field_type:8'h05, offset:16'h0008, size:16'h0004,
            nested:1'b0, nested_type_table:64'h0};
    lo_log.delete(); hi_log.delete();
    load(64'h0);
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL single_timeout: ob_valid=%b want 1", ob_valid); end
    n_checks++;
    if (entry !== exp) begin n_errors++; $display("FAIL single_entry: got %h want %h", entry, exp); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (ob_valid !== 1'b0) begin n_errors++; $display("FAIL single_ob_after: got %b want 0", ob_valid); end
    n_checks++;
    if (dram_en !== 8'h00) begin n_errors++; $display("FAIL single_done_idle: dram_en %h want 00", dram_en); end
    n_checks++;
    if (lo_log.size() !== 2) begin n_errors++; $display("FAIL single_req_count: got %0d want 2", lo_log.size()); end
    n_checks++;
    if (lo_log[0] !== 64'h0 || hi_log[0] !== 64'h7)
      begin n_errors++; $display("FAIL single_req_lo: got %h..%h want 0..7", lo_log[0], hi_log[0]); end
    n_checks++;
    if (lo_log[1] !== 64'h8 || hi_log[1] !== 64'hF)
      begin n_errors++; $display("FAIL single_req_hi: got %h..%h want 8..f", lo_log[1], hi_log[1]); end
  endtask

  task automatic test_two_records();
    TABLE_ENTRY exp0, exp1;
    bit ok;
    exp0 = '{field_id:16'h0001, field_type:8'h0B, offset:16'h0010, size:16'h0020,
             nested:1'b1, nested_type_table:64'h200};
    exp1 = '{field_id:16'h0002, field_type:8'h09, offset:16'h0030, size:16'h0008,
             nested:1'b0, nested_type_table:64'h0};
    lo_log.delete(); hi_log.delete();
    load(64'h100);
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL two_timeout0: ob_valid=%b want 1", ob_valid); end
    n_checks++;
    if (entry !== exp0) begin n_errors++; $display("FAIL two_entry0: got %h want %h", entry, exp0); end
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL two_timeout1: ob_valid=%b want 1", ob_valid); end
    n_checks++;
    if (entry !== exp1) begin n_errors++; $display("FAIL two_entry1: got %h want %h", entry, exp1); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (lo_log.size() !== 4) begin n_errors++; $display("FAIL two_req_count: got %0d want 4", lo_log.size()); end
    n_checks++;
    if (lo_log[2] !== 64'h110 || lo_log[3] !== 64'h118)
      begin n_errors++; $display("FAIL two_second_addr: got %h,%h want 110,118", lo_log[2], lo_log[3]); end
  endtask

  task automatic test_ob_full();
    TABLE_ENTRY exp;
    bit ok;
    int extra;
    exp = '{field_id:16'hBEEF, field_type:8'h12, offset:16'h7777, size:16'h0102,
            nested:1'b1, nested_type_table:64'h0123456789ABCDEF};
    ob_full = 1'b1;
    load(64'h40);
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL full_timeout: ob_valid=%b want 1", ob_valid); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ob_valid !== 1'b1) begin n_errors++; $display("FAIL full_hold_valid: cycle %0d got %b want 1", k, ob_valid); end
      n_checks++;
      if (entry !== exp) begin n_errors++; $display("FAIL full_hold_entry: cycle %0d got %h want %h", k, entry, exp); end
    end
    ob_full = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ob_valid !== 1'b0) begin n_errors++; $display("FAIL full_release: got %b want 0", ob_valid); end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ob_valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_errors++; $display("FAIL full_single_xfer: extra valid cycles %0d want 0", extra); end
  endtask

  task automatic test_stagger();
    TABLE_ENTRY exp;
    bit ok;
    exp = '{field_id:16'h0A0B, field_type:8'h0C, offset:16'h0D0E, size:16'h0F10,
            nested:1'b0, nested_type_table:64'h1122334455667788};
    resp_mode = 1;
    load(64'h80);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (dram_en == 8'hFF) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL stagger_req_timeout: dram_en %h want ff", dram_en); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (dram_en !== 8'hFF || dram_addr[0] !== 64'h80 || dram_addr[7] !== 64'h87) begin
        n_errors++;
        $display("FAIL stagger_hold: cycle %0d en %h addr %h..%h want ff 80..87",
                 k, dram_en, dram_addr[0], dram_addr[7]);
      end
    end
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL stagger_timeout: ob_valid=%b want 1", ob_valid); end
    n_checks++;
    if (entry !== exp) begin n_errors++; $display("FAIL stagger_entry: got %h want %h", entry, exp); end
    resp_mode = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    TABLE_ENTRY exp0, exp1;
    bit ok;
    exp0 = '{field_id:16'h0001, field_type:8'h0B, offset:16'h0010, size:16'h0020,
             nested:1'b1, nested_type_table:64'h200};
    exp1 = '{field_id:16'h0002, field_type:8'h09, offset:16'h0030, size:16'h0008,
             nested:1'b0, nested_type_table:64'h0};
    resp_mode = 2;
    load(64'h0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (dram_en == 8'hFF && dram_addr[0] == 64'h8) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL abort_hi_timeout: en %h addr %h want ff 8", dram_en, dram_addr[0]); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dram_en !== 8'hFF || dram_addr[0] !== 64'h8)
      begin n_errors++; $display("FAIL abort_hi_wait: en %h addr %h want ff 8", dram_en, dram_addr[0]); end
    // Stale data arrives on the very edge that carries the reload.
    resp_mode      = 0;
    new_addr       = 64'h100;
    new_addr_valid = 1'b1;
    @(posedge clk); #1;
    new_addr_valid = 1'b0;
    lo_log.delete(); hi_log.delete();
    n_checks++;
    if (dram_en !== 8'h00) begin n_errors++; $display("FAIL abort_drop_en: got %h want 00", dram_en); end
    n_checks++;
    if (ob_valid !== 1'b0) begin n_errors++; $display("FAIL abort_ob_valid: got %b want 0", ob_valid); end
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL abort_timeout0: ob_valid=%b want 1", ob_valid); end
    n_checks++;
    if (entry !== exp0) begin n_errors++; $display("FAIL abort_entry0: got %h want %h", entry, exp0); end
    n_checks++;
    if (lo_log[0] !== 64'h100 || hi_log[0] !== 64'h107)
      begin n_errors++; $display("FAIL abort_new_req: got %h..%h want 100..107", lo_log[0], hi_log[0]); end
    wait_ob(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL abort_timeout1: ob_valid=%b want 1", ob_valid); end
    n_checks++;
    if (entry !== exp1) begin n_errors++; $display("FAIL abort_entry1: got %h want %h", entry, exp1); end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    resp_mode      = 0;
    resp_cnt       = 0;
    en             = 1'b0;
    new_addr       = '0;
    new_addr_valid = 1'b0;
    ob_full        = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    put_rec(16'h000, 16'h1234, 8'h05, 8'h02, 16'h0008, 16'h0004, 64'h0);
    put_rec(16'h100, 16'h0001, 8'h0B, 8'h01, 16'h0010, 16'h0020, 64'h200);
    put_rec(16'h110, 16'h0002, 8'h09, 8'h02, 16'h0030, 16'h0008, 64'h0);
    put_rec(16'h040, 16'hBEEF, 8'h12, 8'h03, 16'h7777, 16'h0102, 64'h0123456789ABCDEF);
    put_rec(16'h080, 16'h0A0B, 8'h0C, 8'h02, 16'h0D0E, 16'h0F10, 64'h1122334455667788);

    test_reset();
    test_single();
    test_two_records();
    test_ob_full();
    test_stagger();
    test_abort();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
